// File: rtl/pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready and global stall.
// Each stage finishes one SEG-bit segment and skews the upper operand bits.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  logic en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_d;
    logic             c_q;
    logic             vld_q;

    if (k == 0) begin : g_src
      assign a_i = op1;
      assign b_i = sub ? ~op2 : op2;
      assign s_i = '0;
      assign c_i = cin ^ sub;
      assign v_i = in_valid;
    end else begin : g_src
      assign a_i = g_stg[k-1].g_skew.a_q;
      assign b_i = g_stg[k-1].g_skew.b_q;
      assign s_i = g_stg[k-1].s_q;
      assign c_i = g_stg[k-1].c_q;
      assign v_i = g_stg[k-1].vld_q;
    end

    // Lookahead inside each group, ripple between groups.
    always_comb begin : seg
      logic             cc;
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   cg;
      logic             acc;
      logic             pp;
      s_d = s_i;
      cc  = c_i;
      g   = '0;
      p   = '0;
      cg  = '0;
      acc = 1'b0;
      pp  = 1'b0;
      for (int j = 0; j < NGRP; j++) begin
        g = a_i[k*SEG+j*BLOCK +: BLOCK]
          & b_i[k*SEG+j*BLOCK +: BLOCK];
        p = a_i[k*SEG+j*BLOCK +: BLOCK]
          ^ b_i[k*SEG+j*BLOCK +: BLOCK];
        cg[0] = cc;
        for (int i = 1; i <= BLOCK; i++) begin
          acc = 1'b0;
          pp  = 1'b1;
          for (int m = i - 1; m >= 0; m--) begin
            acc = acc | (pp & g[m]);
            pp  = pp & p[m];
          end
          cg[i] = acc | (pp & cc);
        end
        s_d[k*SEG+j*BLOCK +: BLOCK] = p ^ cg[BLOCK-1:0];
        cc = cg[BLOCK];
      end
      c_d = cc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        vld_q <= v_i;
        s_q   <= s_d;
        c_q   <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_i;
          b_q <= b_i;
        end
      end
    end else begin : g_last
      logic v_q;
      logic z_q;
      logic n_q;
      logic cm;
      // Carry into the MSB recovered from its sum bit.
      assign cm = s_d[WIDTH-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
          n_q <= 1'b0;
        end else if (en) begin
          v_q <= cm ^ c_d;
          z_q <= ~|s_d;
          n_q <= s_d[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign carry     = g_stg[STAGES-1].c_q;
  assign v_flag    = g_stg[STAGES-1].g_last.v_q;
  assign z_flag    = g_stg[STAGES-1].g_last.z_q;
  assign n_flag    = g_stg[STAGES-1].g_last.n_q;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder with back-pressure
// and mid-stream reset; results are packed as {n,z,v,carry,sum}.
module tb_pipelined_adder;

  localparam int W   = 32;
  localparam int BLK = 4;
  localparam int ST  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         v_flag;
  logic         z_flag;
  logic         n_flag;

  pipelined_adder #(
    .WIDTH (W),
    .BLOCK (BLK),
    .STAGES(ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .v_flag   (v_flag),
    .z_flag   (z_flag),
    .n_flag   (n_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W+3:0] r;
  } stim_t;

  typedef struct {
    logic [W+3:0] r;
    int           cyc;
  } exp_t;

  stim_t stim_q[$];
  string stag_q[$];
  exp_t  exp_q[$];
  string etag_q[$];

  int n_run  = 0;
  int n_fail = 0;

  logic [W-1:0] corners [6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                32'h8000_0000, 32'h1, 32'hFFFF_FFFE};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference in WIDTH+1 bits; signed overflow from operand/result signs.
  function automatic logic [W+3:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    logic [W:0] r;
    logic       v;
    if (sb) begin
      r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      r[W] = ~r[W];
      v    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {r[W-1], ~|r[W-1:0], v, r[W], r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  task automatic add_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb,
                        input logic [W+3:0] r, input string tag);
    stim_t s;
    s = '{a, b, ci, sb, r};
    stim_q.push_back(s);
    stag_q.push_back(tag);
  endtask

  // Drive the stimulus queue and score outputs; out_ready low for cycles lo..hi.
  task automatic run(input int lo, input int hi, input int budget,
                     input bit latchk);
    int           c;
    bit           stl;
    logic [W+3:0] cur;
    logic [W+3:0] held;
    exp_t         e;
    string        t;
    c    = 0;
    stl  = 1'b0;
    held = '0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= lo && c <= hi);
      if (stim_q.size() != 0) begin
        in_valid = 1'b1;
        op1      = stim_q[0].a;
        op2      = stim_q[0].b;
        cin      = stim_q[0].ci;
        sub      = stim_q[0].sb;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cur = {n_flag, z_flag, v_flag, carry, sum};
      if (stl) check("hold", 64'({out_valid, cur}), 64'({1'b1, held}));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'(0));
        held = cur;
        stl  = 1'b1;
      end else begin
        stl = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          t = etag_q.pop_front();
          check(t, 64'(cur), 64'(e.r));
          if (latchk) check({t, "_lat"}, 64'(c - e.cyc), 64'(ST));
        end
      end
      if (in_valid && in_ready) begin
        e = '{stim_q[0].r, c};
        exp_q.push_back(e);
        etag_q.push_back(stag_q.pop_front());
        void'(stim_q.pop_front());
      end
      c++;
    end
    check("run_drained", 64'(stim_q.size() + exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    int           lo;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op1       = '0;
    op2       = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({n_flag, z_flag, v_flag, carry, sum}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    add_op(32'hFFFF_FFFF, 32'h1, 0, 0, {4'b0101, 32'h0}, "cross_seg");
    add_op(32'h7FFF_FFFF, 32'h1, 0, 0, {4'b1010, 32'h8000_0000}, "ovf_add");
    add_op(32'h8000_0000, 32'h1, 0, 1, {4'b0011, 32'h7FFF_FFFF}, "ovf_sub");
    add_op(32'h5, 32'h7, 0, 1, {4'b1000, 32'hFFFF_FFFE}, "neg_sub");
    add_op(32'd10, 32'd3, 1, 1, {4'b0001, 32'd6}, "borrow_in");
    add_op(32'h0000_FFFF, 32'h0000_FFFF, 1, 0, {4'b0000, 32'h0001_FFFF},
           "seg_carry_cin");
    add_op(32'h0, 32'h0, 0, 1, {4'b0101, 32'h0}, "zero_sub");
    add_op(32'h0, 32'h1, 0, 1, {4'b1000, 32'hFFFF_FFFF}, "zero_minus1");
    add_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, {4'b1001, 32'hFFFF_FFFF},
           "m1_m1_cin");
    run(-1, -2, 60, 1'b1);

    for (int i = 0; i < 8; i++)
      add_op(W'(i), W'(i), 0, 0, {1'b0, i == 0, 2'b00, W'(2 * i)}, "bp_seq");
    run(3, 6, 60, 1'b0);

    for (int i = 0; i < 100; i++) begin
      a  = pick();
      b  = pick();
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      add_op(a, b, ci, sb, model(a, b, ci, sb), "rand_lat");
    end
    run(-1, -2, 300, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 50; i++) begin
        a  = pick();
        b  = pick();
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        add_op(a, b, ci, sb, model(a, b, ci, sb), "rand_stall");
      end
      lo = $urandom_range(0, 40);
      run(lo, lo + $urandom_range(1, 6), 300, 1'b0);
    end

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op1       = 32'd1;
    op2       = 32'd1;
    cin       = 1'b0;
    sub       = 1'b0;
    @(posedge clk);
    #1;
    op1 = 32'd2;
    op2 = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    check("pre_rst_sum", 64'(sum), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_outs", 64'({n_flag, z_flag, v_flag, carry, sum}),
          64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_idle", 64'(out_valid), 64'(0));
    add_op(32'hA, 32'h5, 0, 0, {4'b0000, 32'hF}, "post_rst");
    run(-1, -2, 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
